// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port sync-read framebuffer RAM between pixel-doubled VGA scan-out
// (absolute priority on even active pixels) and a req/ack host port served in all other cycles.
module vram_arbiter #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int FB_W = 320,
    parameter int FB_H = 240,
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [9:0]        px,
    input  logic [9:0]        py,
    output logic [11:0]       color,
    output logic              frame_start,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [11:0]       host_wdata,
    output logic              host_ack,
    output logic [11:0]       host_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [11:0]       ram_wdata,
    input  logic [11:0]       ram_rdata
);
    typedef enum logic [1:0] {IDLE, RD_WAIT, ACK} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_SCAN, OWN_HOST} owner_t;
    state_t state, state_nx;
    owner_t owner;
    logic rd_oor;
    logic scan_slot, issue, in_range;
    logic [ADDR_W-1:0] scan_addr;
    assign scan_slot = (px < 10'(H_ACTIVE)) && (py < 10'(V_ACTIVE)) && !px[0];
    assign scan_addr = ADDR_W'(py[9:1]) * ADDR_W'(FB_W) + ADDR_W'(px[9:1]);
    assign in_range = host_addr < ADDR_W'(FB_W * FB_H);
    assign issue = (state == IDLE) && host_req && !scan_slot;
    assign ram_addr = scan_slot ? scan_addr : host_addr;
    assign ram_we = issue && host_we && in_range && !rst;
    assign ram_wdata = host_wdata;
    assign host_ack = state == ACK;
    always_comb begin
        state_nx = IDLE;
        case (state)
            IDLE:    state_nx = issue ? (host_we ? ACK : RD_WAIT) : IDLE;
            RD_WAIT: state_nx = ACK;
            default: state_nx = IDLE;
        endcase
    end
    // owner tag follows the RAM's one-cycle read latency so returning data is steered correctly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            owner       <= OWN_NONE;
            rd_oor      <= 1'b0;
            color       <= '0;
            host_rdata  <= '0;
            frame_start <= 1'b0;
        end else begin
            state       <= state_nx;
            owner       <= scan_slot ? OWN_SCAN : (issue && !host_we) ? OWN_HOST : OWN_NONE;
            rd_oor      <= !in_range;
            if (owner == OWN_SCAN) color <= ram_rdata;
            if (owner == OWN_HOST) host_rdata <= rd_oor ? '0 : ram_rdata;
            frame_start <= (px == '0) && (py == 10'(V_ACTIVE));
        end
    end
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: randomized + directed bench; a cycle-level behavioural model of slots, host
// transactions and pixel pipeline checks every DUT output each cycle against a bench-side RAM.
module tb_vram_arbiter;
    localparam int FB_PIX = 76800;
    typedef struct packed { logic we; logic [16:0] a; logic [11:0] d; } op_t;
    logic clk = 0, rst = 1;
    logic [9:0] px = 0, py = 0;
    logic [11:0] color, host_rdata, ram_wdata, ram_rdata;
    logic frame_start, host_ack, ram_we;
    logic host_req = 0, host_we = 0;
    logic [16:0] host_addr = 0, ram_addr;
    logic [11:0] host_wdata = 0;
    bit [11:0] ram_d [0:131071];
    bit ram_w [0:131071];
    bit [11:0] mm_d [0:FB_PIX-1];
    bit mm_w [0:FB_PIX-1];
    int n_chk, n_fail, cyc, req_age;
    op_t opq[$];
    int next_ok, ack_cyc;
    bit ack_rd, fs_due;
    logic [11:0] rd_val, exp_color, exp_rdata;
    int cq_cyc[$];
    logic [11:0] cq_val[$];

    vram_arbiter dut (
        .clk(clk), .rst(rst), .px(px), .py(py), .color(color), .frame_start(frame_start),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_ack(host_ack), .host_rdata(host_rdata), .ram_addr(ram_addr), .ram_we(ram_we),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] init_val(int a);
        return 12'(a * 7 + (a >>> 12) + 3);
    endfunction

    function automatic logic [11:0] mem(int a);
        return mm_w[a] ? mm_d[a] : init_val(a);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d px=%0d py=%0d)", nm, act, exp, cyc, px, py);
        end
    endtask

    // power-up contents come from init_val until a location is written
    always @(posedge clk) begin
        if (ram_we) begin
            ram_d[ram_addr] <= ram_wdata;
            ram_w[ram_addr] <= 1'b1;
        end
        ram_rdata <= ram_w[ram_addr] ? ram_d[ram_addr] : init_val(int'(ram_addr));
    end

    // reference model and per-cycle compare
    always @(negedge clk) begin
        bit scan, issue, inr;
        int sa, ha;
        cyc++;
        if (rst) begin
            chk("rst_color", int'(color), 0);
            chk("rst_ack", int'(host_ack), 0);
            chk("rst_rdata", int'(host_rdata), 0);
            chk("rst_frame_start", int'(frame_start), 0);
            chk("rst_ram_we", int'(ram_we), 0);
            next_ok = 0; ack_cyc = -1; ack_rd = 0; exp_color = 0; exp_rdata = 0; fs_due = 0;
            cq_cyc.delete(); cq_val.delete();
        end else begin
            scan = px < 640 && py < 480 && px % 2 == 0;
            sa = (int'(py) / 2) * 320 + int'(px) / 2;
            ha = int'(host_addr);
            inr = ha < FB_PIX;
            issue = host_req && !scan && cyc >= next_ok;
            chk("ram_we", int'(ram_we), int'(issue && host_we && inr));
            if (scan) chk("scan_addr", int'(ram_addr), sa);
            if (issue) chk("host_issue_addr", int'(ram_addr), ha);
            if (issue && host_we && inr) chk("ram_wdata", int'(ram_wdata), int'(host_wdata));
            if (cq_cyc.size() > 0 && cq_cyc[0] == cyc) begin
                exp_color = cq_val.pop_front();
                void'(cq_cyc.pop_front());
            end
            chk("color", int'(color), int'(exp_color));
            if (cyc == ack_cyc && ack_rd) exp_rdata = rd_val;
            chk("host_ack", int'(host_ack), int'(cyc == ack_cyc));
            chk("host_rdata", int'(host_rdata), int'(exp_rdata));
            chk("frame_start", int'(frame_start), int'(fs_due));
            fs_due = px == 0 && py == 480;
            if (scan) begin
                cq_cyc.push_back(cyc + 2);
                cq_val.push_back(mem(sa));
            end
            if (issue && host_we) begin
                if (inr) begin mm_d[ha] = host_wdata; mm_w[ha] = 1; end
                ack_cyc = cyc + 1; ack_rd = 0; next_ok = cyc + 2;
            end else if (issue) begin
                rd_val = inr ? mem(ha) : 12'h0;
                ack_cyc = cyc + 2; ack_rd = 1; next_ok = cyc + 3;
            end
        end
    end

    task automatic host_op(input bit we, input int a, input int d);
        opq.push_back('{we: we, a: 17'(a), d: 12'(d)});
    endtask

    // one clock: host driver (holds request until ack) and beam advance or jump
    task automatic step(input int jx = -1, input int jy = -1);
        bit drop;
        op_t o;
        drop = host_req && host_ack;
        @(posedge clk);
        #1;
        if (drop || rst) host_req = 0;
        if (host_req) req_age++;
        if (host_req && req_age > 12) begin
            n_chk++; n_fail++;
            $display("FAIL host_timeout: no ack after %0d cycles, addr %0h", req_age, host_addr);
            host_req = 0;
        end
        if (jx >= 0) begin
            px = 10'(jx); py = 10'(jy);
        end else begin
            px = (px == 799) ? 10'd0 : px + 10'd1;
            if (px == 0) py = (py == 524) ? 10'd0 : py + 10'd1;
        end
        if (!host_req && !rst && opq.size() > 0) begin
            o = opq.pop_front();
            host_req = 1; host_we = o.we; host_addr = o.a; host_wdata = o.d; req_age = 0;
        end else if (!host_req) begin
            host_we = 1'($urandom); host_addr = 17'($urandom); host_wdata = 12'($urandom);
        end
        #1;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((opq.size() > 0 || host_req) && t < 200) begin step(); t++; end
        chk("drain_done", int'(opq.size() > 0 || host_req), 0);
        repeat (2) step();
    endtask

    initial begin
        int r, a;
        repeat (6) step();
        chk("lit_rst_color", int'(color), 0);
        chk("lit_rst_ram_we", int'(ram_we), 0);
        rst = 0;
        step(); step();
        chk("lit_first_fetch", int'(color), int'(init_val(3)));
        step(0, 500);
        host_op(1, 0, 'hABC); host_op(1, 1, 'h123); host_op(1, 5, 'hF0F);
        drain();
        step(0, 0);
        chk("lit_scan_we", int'(ram_we), 0);
        step();
        step(); chk("lit_color_t2", int'(color), 'hABC);
        step(); chk("lit_color_t3", int'(color), 'hABC);
        step(); chk("lit_color_t4", int'(color), 'h123);
        step(); chk("lit_color_t5", int'(color), 'h123);
        step(0, 480);
        step(); chk("lit_frame_start", int'(frame_start), 1);
        step(); chk("lit_frame_start_end", int'(frame_start), 0);
        host_op(1, 4800, 'h5A5);
        step(10, 0);
        chk("lit_px10_addr", int'(ram_addr), 5);
        chk("lit_px10_we", int'(ram_we), 0);
        step();
        chk("lit_px11_addr", int'(ram_addr), 4800);
        chk("lit_px11_we", int'(ram_we), 1);
        step();
        chk("lit_px12_ack", int'(host_ack), 1);
        chk("lit_px12_addr", int'(ram_addr), 6);
        drain();
        host_op(0, 4800, 0);
        drain();
        chk("lit_readback_4800", int'(host_rdata), 'h5A5);
        host_op(0, 5, 0);
        step(0, 500);
        chk("lit_rd_issue_addr", int'(ram_addr), 5);
        step(); chk("lit_rd_t1_ack", int'(host_ack), 0);
        step(); chk("lit_rd_t2_ack", int'(host_ack), 1);
        chk("lit_rd_t2_data", int'(host_rdata), 'hF0F);
        step(); chk("lit_rd_t3_ack", int'(host_ack), 0);
        drain();
        host_op(0, 1, 0);
        step(0, 500);
        step();
        rst = 1;
        #1;
        chk("lit_arst_ack", int'(host_ack), 0);
        chk("lit_arst_rdata", int'(host_rdata), 0);
        chk("lit_arst_color", int'(color), 0);
        step(); step();
        rst = 0;
        host_op(0, 1, 0);
        drain();
        chk("lit_rerequest", int'(host_rdata), 'h123);
        host_op(1, FB_PIX, 'h777);
        step(0, 500);
        chk("lit_oor_we", int'(ram_we), 0);
        drain();
        host_op(0, FB_PIX, 0);
        drain();
        chk("lit_oor_read", int'(host_rdata), 0);
        repeat (4000) begin
            r = $urandom_range(0, 99);
            if (r < 3) step($urandom_range(0, 799), $urandom_range(0, 524));
            else if (r == 3) step(636, 479);
            else if (r == 4) step(798, 479);
            else if (r == 5) step(797, 524);
            else step();
            if (opq.size() < 2 && $urandom_range(0, 2) == 0) begin
                r = $urandom_range(0, 19);
                a = (r == 0) ? FB_PIX + $urandom_range(0, 3000) : (r == 1) ? FB_PIX - 1 :
                    (r == 2) ? FB_PIX : $urandom_range(0, FB_PIX - 1);
                host_op(1'($urandom), a, $urandom_range(0, 4095));
            end
        end
        drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
